traffic_phase_sched: RTL and testbench
======================================

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 SHALL have parameter GREEN_T, default 5, minimum green duration in ticks (>=1).
REQ-002 SHALL have parameter YELLOW_T, default 1, yellow duration in ticks (>=1).
REQ-003 SHALL have parameter ALLRED_T, default 1, all-red clearance duration in ticks (>=1).
REQ-004 SHALL have parameter WALK_T, default 4, pedestrian walk duration in ticks (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port tick  input  1  timing enable; counters advance only when 1.
REQ-008 SHALL have port sensor_a  input  1  vehicle waiting on road A (level).
REQ-009 SHALL have port sensor_b  input  1  vehicle waiting on road B (level).
REQ-010 SHALL have port ped_req  input  1  pedestrian request (pulse, any length).
REQ-011 SHALL have port emerg  input  1  emergency preemption request (level).
REQ-012 SHALL have port light_A  output  3  road A lamp, one-hot: 001 green, 010 yellow, 100 red.
REQ-013 SHALL have port light_B  output  3  road B lamp, same encoding.
REQ-014 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-015 SHALL have port ped_ack  output  1  one-cycle pulse when a pending request is served.
REQ-016 SHALL have port state_o  output  3  current state code, for debug.

Function
REQ-017 SHALL implement states A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5, WALK=6, EMERG=7.
REQ-018 SHALL hold a phase counter cleared on every state entry, incremented on tick; a timed state exits on a tick cycle where counter == duration-1.
REQ-019 SHALL freeze the state and counter while tick=0, except for emerg and rst handling.
REQ-020 SHALL on A_GRN expiry move to A_YEL only if sensor_b=1 or ped_pend=1; otherwise rest in A_GRN, leaving on the first tick when either becomes 1. B_GRN is symmetric with sensor_a.
REQ-021 SHALL sequence A_YEL->AR_AB->B_GRN and B_YEL->AR_BA->A_GRN.
REQ-022 SHALL on AR_* expiry with ped_pend=1 enter WALK instead, then on WALK expiry enter the green AR_* would have entered (held in a next_b flag).
REQ-023 SHALL latch ped_req into ped_pend; on WALK entry pulse ped_ack for one cycle and clear ped_pend; a ped_req in the entry cycle is absorbed.
REQ-024 SHALL on any cycle with emerg=1: X_GRN->X_YEL at once (counter cleared); X_YEL finishes YELLOW_T then ->EMERG; AR_* or WALK ->EMERG at once (walk cut, ped_pend kept).
REQ-025 SHALL hold EMERG while emerg=1; on the first tick with emerg=0 enter AR_BA (next green A).
REQ-026 SHALL decode outputs combinationally from the state: A_GRN 001/100, A_YEL 010/100, B_GRN 100/001, B_YEL 100/010, other states 100/100; walk=1 only in WALK.
REQ-027 SHALL never drive green on both roads, and never green on a road while walk=1.

Reset
REQ-028 SHALL on rst=1 at a clk edge set state A_GRN, counter 0, ped_pend 0, next_b 0; rst overrides all inputs.
REQ-029 SHALL give reset outputs light_A=001, light_B=100, walk=0, ped_ack=0, state_o=0.

Configuration
REQ-030 SHALL, with PED_CROSS_EN defined, implement ped_pend, WALK, walk and ped_ack as above.
REQ-031 SHALL, without PED_CROSS_EN, ignore ped_req, tie walk and ped_ack to 0, never enter WALK, and treat ped_pend as 0 in REQ-020.

Verification (defaults, tick=1 every cycle, PED_CROSS_EN defined unless noted)
REQ-032 SHALL cover: reset, sensor_a=sensor_b=1 -> A_GRN 5, A_YEL 1, AR_AB 1, B_GRN 5, B_YEL 1, AR_BA 1 cycles; 14-cycle period.
REQ-033 SHALL cover: sensor_b=0 -> A_GRN held past cycle 5; sensor_b=1 at cycle 20 -> A_YEL from cycle 21.
REQ-034 SHALL cover: ped_req pulse at cycle 2 -> A_YEL at 5, AR_AB at 6, WALK cycles 7-10 with walk=1, ped_ack=1 at 7 only, B_GRN at 11.
REQ-035 SHALL cover: emerg=1 at B_GRN cycle 2 -> B_YEL 1 cycle, then EMERG with both lamps 100; emerg=0 -> AR_BA 1 cycle, then A_GRN.
REQ-036 SHALL cover: rst pulse mid-WALK -> next edge state 0, walk=0, ped_pend=0, light_A=001.
REQ-037 SHALL cover: PED_CROSS_EN undefined, ped_req pulses -> walk and ped_ack stay 0, 14-cycle sequence unchanged.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// Two-road traffic phase scheduler with emergency preemption.
// Optional pedestrian crossing phase enabled by PED_CROSS_EN.
// Ports:
//   clk, rst (sync, active-high), tick (timing enable)
//   sensor_a, sensor_b (vehicle waiting), ped_req, emerg
//   light_A, light_B (001 grn, 010 yel, 100 red), walk,
//   ped_ack (one-cycle serve pulse), state_o (debug code)
module traffic_phase_sched #(
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6,
    EMERG = 3'd7
  } state_t;

  localparam int M1 =
    (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int M2 =
    (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int MAXD = (M1 > M2) ? M1 : M2;
  localparam int CW = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [CW-1:0] G_LAST = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] R_LAST = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WALK_T - 1);

  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_RED = 3'b100;

`ifdef PED_CROSS_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;
  logic          done;
  logic          next_b_q, next_b_d;
  logic          ped_pend_q;

  // Counter saturates at the state's last value so a
  // resting green keeps reporting expiry.
  always_comb begin
    last = '0;
    unique case (state_q)
      A_GRN, B_GRN: last = G_LAST;
      A_YEL, B_YEL: last = Y_LAST;
      AR_AB, AR_BA: last = R_LAST;
      WALK:         last = W_LAST;
      EMERG:        last = '0;
    endcase
  end

  assign done = (cnt_q == last);

  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    unique case (state_q)
      A_GRN: begin
        if (emerg)
          state_d = A_YEL;
        else if (tick && done && (sensor_b || ped_pend_q))
          state_d = A_YEL;
      end
      A_YEL: begin
        if (tick && done)
          state_d = emerg ? EMERG : AR_AB;
      end
      AR_AB: begin
        if (emerg) begin
          state_d = EMERG;
        end else if (tick && done) begin
          if (ped_pend_q) begin
            state_d  = WALK;
            next_b_d = 1'b1;
          end else begin
            state_d = B_GRN;
          end
        end
      end
      B_GRN: begin
        if (emerg)
          state_d = B_YEL;
        else if (tick && done && (sensor_a || ped_pend_q))
          state_d = B_YEL;
      end
      B_YEL: begin
        if (tick && done)
          state_d = emerg ? EMERG : AR_BA;
      end
      AR_BA: begin
        if (emerg) begin
          state_d = EMERG;
        end else if (tick && done) begin
          if (ped_pend_q) begin
            state_d  = WALK;
            next_b_d = 1'b0;
          end else begin
            state_d = A_GRN;
          end
        end
      end
      WALK: begin
        if (emerg)
          state_d = EMERG;
        else if (tick && done)
          state_d = next_b_q ? B_GRN : A_GRN;
      end
      EMERG: begin
        if (!emerg && tick)
          state_d = AR_BA;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (tick && !done)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= A_GRN;
      cnt_q    <= '0;
      next_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      next_b_q <= next_b_d;
    end
  end

`ifdef PED_CROSS_EN
  logic ped_pend_d;
  logic ped_ack_q, ped_ack_d;
  logic walk_entry;

  // A request arriving in the entry cycle is absorbed.
  always_comb begin
    walk_entry = (state_d == WALK) && (state_q != WALK);
    ped_pend_d = walk_entry ? 1'b0 : (ped_pend_q | ped_req);
    ped_ack_d  = walk_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  assign ped_ack = ped_ack_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_pend_q = 1'b0;
  assign ped_ack    = 1'b0;
`endif

  always_comb begin
    light_A = L_RED;
    light_B = L_RED;
    walk    = 1'b0;
    unique case (state_q)
      A_GRN: light_A = L_GRN;
      A_YEL: light_A = L_YEL;
      B_GRN: light_B = L_GRN;
      B_YEL: light_B = L_YEL;
      WALK:  walk    = PED_ON;
      AR_AB, AR_BA, EMERG: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed scoreboard bench for traffic_phase_sched.
// Expectations follow the ped build selected by PED_CROSS_EN.
module tb_traffic_phase_sched;

  localparam logic [2:0] S_AG = 3'd0;
  localparam logic [2:0] S_AY = 3'd1;
  localparam logic [2:0] S_RAB = 3'd2;
  localparam logic [2:0] S_BG = 3'd3;
  localparam logic [2:0] S_BY = 3'd4;
  localparam logic [2:0] S_RBA = 3'd5;
  localparam logic [2:0] S_WK = 3'd6;
  localparam logic [2:0] S_EM = 3'd7;

  logic clk = 1'b0;
  logic rst, tick, sensor_a, sensor_b, ped_req, emerg;
  logic [2:0] light_A, light_B, state_o;
  logic walk, ped_ack;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    string      tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb_q[$];

  traffic_phase_sched dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .ped_req  (ped_req),
    .emerg    (emerg),
    .light_A  (light_A),
    .light_B  (light_B),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(
    input logic [2:0] st, input logic ack);
    logic [2:0] la, lb;
    logic w;
    la = 3'b100;
    lb = 3'b100;
    w  = 1'b0;
    case (st)
      S_AG: la = 3'b001;
      S_AY: la = 3'b010;
      S_BG: lb = 3'b001;
      S_BY: lb = 3'b010;
      S_WK: w  = 1'b1;
      default: ;
    endcase
    return {st, la, lb, w, ack};
  endfunction

  // 14-cycle all-sensors cycle position -> state
  function automatic logic [2:0] seq_st(input int c);
    int m;
    m = c % 14;
    if (m < 5)  return S_AG;
    if (m == 5) return S_AY;
    if (m == 6) return S_RAB;
    if (m < 12) return S_BG;
    if (m == 12) return S_BY;
    return S_RBA;
  endfunction

  // ped pulse at cycle 2, no vehicles
  function automatic logic [2:0] ped_st(input int c);
    if (c < 5)  return S_AG;
    if (c == 5) return S_AY;
    if (c == 6) return S_RAB;
    if (c < 11) return S_WK;
    return S_BG;
  endfunction

  task automatic step(
    input logic r, input logic tk,
    input logic sa, input logic sbv,
    input logic pr, input logic em,
    input logic [2:0] est, input logic eack,
    input string tag);
    exp_t e;
    logic [10:0] got;
    rst      = r;
    tick     = tk;
    sensor_a = sa;
    sensor_b = sbv;
    ped_req  = pr;
    emerg    = em;
    e.tag = tag;
    e.v   = mk(est, eack);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = {state_o, light_A, light_B, walk, ped_ack};
    n_tot++;
    assert (got === e.v) n_pass++;
    else $error("FAIL %s: got st=%0d A=%b B=%b w=%b ack=%b, want st=%0d A=%b B=%b w=%b ack=%b",
                e.tag, got[10:8], got[7:5], got[4:2], got[1], got[0],
                e.v[10:8], e.v[7:5], e.v[4:2], e.v[1], e.v[0]);
  endtask

  task automatic do_reset(input string tag);
    step(1, 1, 1, 1, 1, 1, S_AG, 0, tag);
  endtask

  initial begin
    rst = 1; tick = 0; sensor_a = 0;
    sensor_b = 0; ped_req = 0; emerg = 0;

    // reset state and full 14-cycle rotation
    do_reset("reset");
    for (int c = 0; c < 15; c++) begin
      logic pr;
`ifdef PED_CROSS_EN
      pr = 1'b0;
`else
      pr = (c == 2) || (c == 8);
`endif
      step(0, 1, 1, 1, pr, 0, seq_st(c + 1), 0, "rotation");
    end

    // resting green, released by sensor_b
    do_reset("reset_rest");
    for (int c = 0; c < 20; c++)
      step(0, 1, 0, 0, 0, 0, S_AG, 0, "rest_hold");
    step(0, 1, 0, 1, 0, 0, S_AY, 0, "rest_yel21");
    step(0, 1, 0, 1, 0, 0, S_RAB, 0, "rest_ar");
    step(0, 1, 0, 1, 0, 0, S_BG, 0, "rest_bgrn");

    // tick freeze of counter and state
    do_reset("reset_tick");
    for (int c = 0; c < 3; c++)
      step(0, 1, 1, 1, 0, 0, S_AG, 0, "tick_run");
    for (int c = 0; c < 3; c++)
      step(0, 0, 1, 1, 0, 0, S_AG, 0, "tick_frz");
    step(0, 1, 1, 1, 0, 0, S_AG, 0, "tick_g4");
    step(0, 1, 1, 1, 0, 0, S_AY, 0, "tick_yel");
    step(0, 0, 1, 1, 0, 0, S_AY, 0, "tick_yfrz");
    step(0, 1, 1, 1, 0, 0, S_RAB, 0, "tick_ar");

    // pedestrian phase
    do_reset("reset_ped");
`ifdef PED_CROSS_EN
    for (int c = 0; c < 12; c++)
      step(0, 1, 0, 0, c == 2, 0, ped_st(c + 1),
           (c + 1) == 7, "ped_seq");
`else
    for (int c = 0; c < 10; c++)
      step(0, 1, 0, 0, c == 2, 0, S_AG, 0, "ped_ignored");
`endif

    // emergency from B_GRN
    do_reset("reset_em");
    for (int c = 0; c < 9; c++)
      step(0, 1, 1, 1, 0, 0, seq_st(c + 1), 0, "em_pre");
    step(0, 1, 1, 1, 0, 1, S_BY, 0, "em_byel");
    step(0, 1, 1, 1, 0, 1, S_EM, 0, "em_enter");
    for (int c = 0; c < 3; c++)
      step(0, 1, 1, 1, 0, 1, S_EM, 0, "em_hold");
    step(0, 0, 1, 1, 0, 0, S_EM, 0, "em_notick");
    step(0, 1, 1, 1, 0, 0, S_RBA, 0, "em_arba");
    step(0, 1, 1, 1, 0, 0, S_AG, 0, "em_agrn");
    // emerg from A_GRN acts without tick
    step(0, 0, 1, 1, 0, 1, S_AY, 0, "em_ayel_now");
    step(0, 0, 1, 1, 0, 1, S_AY, 0, "em_ayel_frz");
    step(0, 1, 1, 1, 0, 1, S_EM, 0, "em_from_ay");
    step(0, 1, 1, 1, 0, 0, S_RBA, 0, "em_arba2");
    step(0, 1, 1, 1, 0, 0, S_AG, 0, "em_agrn2");

`ifdef PED_CROSS_EN
    // reset mid-WALK clears a freshly latched request
    do_reset("reset_rw");
    for (int c = 0; c < 7; c++)
      step(0, 1, 0, 0, c == 2, 0, ped_st(c + 1),
           (c + 1) == 7, "rw_pre");
    step(0, 1, 0, 0, 1, 0, S_WK, 0, "rw_req");
    step(1, 1, 0, 0, 0, 0, S_AG, 0, "rw_rst");
    for (int c = 0; c < 8; c++)
      step(0, 1, 0, 0, 0, 0, S_AG, 0, "rw_nopend");

    // emergency cuts WALK
    do_reset("reset_ew");
    for (int c = 0; c < 7; c++)
      step(0, 1, 0, 0, c == 2, 0, ped_st(c + 1),
           (c + 1) == 7, "ew_pre");
    step(0, 1, 0, 0, 0, 1, S_EM, 0, "ew_cut");
    step(0, 1, 0, 0, 0, 1, S_EM, 0, "ew_hold");
    step(0, 1, 0, 0, 0, 0, S_RBA, 0, "ew_arba");
    step(0, 1, 0, 0, 0, 0, S_AG, 0, "ew_agrn");
`else
    // reset mid-sequence
    do_reset("reset_rm");
    for (int c = 0; c < 6; c++)
      step(0, 1, 1, 1, 0, 0, seq_st(c + 1), 0, "rm_pre");
    step(1, 1, 1, 1, 1, 0, S_AG, 0, "rm_rst");
    for (int c = 0; c < 7; c++)
      step(0, 1, 1, 1, 0, 0, seq_st(c + 1), 0, "rm_post");
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
